// File: rtl/i2s_pkg.sv
// Shared types and elaboration helpers for the i2s_tx_stream transmitter.
// Optional build macro used by the top: I2S_TX_REPEAT_EN.
package i2s_pkg;

    typedef enum logic {
        I2S_MODE_PHILIPS = 1'b0,
        I2S_MODE_LJ      = 1'b1
    } i2s_mode_e;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int data_w, input int slot_w, input int sclk_div);
        return (data_w >= 1) && (data_w <= slot_w) && (sclk_div >= 2) && ((sclk_div % 2) == 0);
    endfunction

endpackage

// File: rtl/i2s_tx_stream_clkgen.sv
// Bit-clock / word-select generator: divides clk_i2s down to SCLK and counts
// bit positions within a stereo frame, emitting fall and frame-load strobes.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SLOT_W   = 32,
    parameter int SCLK_DIV = 4
) (
    input  logic clk_i2s,
    input  logic reset,
    output logic tx_sclk,
    output logic tx_lrclk,
    output logic fall_tick,
    output logic load_tick
);

    localparam int DW = cnt_w(SCLK_DIV);
    localparam int BW = cnt_w(2 * SLOT_W);
    localparam logic [DW-1:0] DIV_MAX     = DW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_RISE_M1 = DW'(SCLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_MAX     = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] SLOT_START  = BW'(SLOT_W);

    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sclk_q, sclk_d;
    logic          lrclk_q, lrclk_d;

    // Strobes are asserted in the cycle before the edge they describe.
    assign fall_tick = (div_q == DIV_MAX);
    assign load_tick = fall_tick && (bit_q == BIT_MAX);

    always_comb begin
        div_d   = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        lrclk_d = lrclk_q;
        if (fall_tick) begin
            bit_d   = (bit_q == BIT_MAX) ? '0 : bit_q + 1'b1;
            sclk_d  = 1'b0;
            lrclk_d = (bit_d >= SLOT_START);
        end else if (div_q == DIV_RISE_M1) begin
            sclk_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i2s or posedge reset) begin
        if (reset) begin
            div_q   <= DIV_MAX;
            bit_q   <= BIT_MAX;
            sclk_q  <= 1'b1;
            lrclk_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            lrclk_q <= lrclk_d;
        end
    end

    assign tx_sclk  = sclk_q;
    assign tx_lrclk = lrclk_q;

endmodule

// File: rtl/i2s_tx_stream.sv
// Stereo I2S / left-justified transmitter fed by a valid/ready stream through a
// one-entry holding register. Define I2S_TX_REPEAT_EN to repeat the last pair on underrun.
module i2s_tx_stream
    import i2s_pkg::*;
#(
    parameter int        DATA_W   = 24,
    parameter int        SLOT_W   = 32,
    parameter int        SCLK_DIV = 4,
    parameter i2s_mode_e MODE     = I2S_MODE_PHILIPS
) (
    input  logic              clk_i2s,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data_l,
    input  logic [DATA_W-1:0] tx_data_r,
    output logic              tx_mclk,
    output logic              tx_sclk,
    output logic              tx_lrclk,
    output logic              tx_sd,
    output logic              tx_underrun
`ifdef I2S_TX_REPEAT_EN
    ,
    output logic [7:0]        tx_underrun_cnt
`endif
);

    localparam int FW = 2 * SLOT_W;

    if (!params_ok(DATA_W, SLOT_W, SCLK_DIV)) begin : g_param_err
        $error("i2s_tx_stream: illegal DATA_W/SLOT_W/SCLK_DIV combination");
    end

    logic fall_tick, load_tick;

    i2s_clkgen #(
        .SLOT_W   (SLOT_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_clkgen (
        .clk_i2s   (clk_i2s),
        .reset     (reset),
        .tx_sclk   (tx_sclk),
        .tx_lrclk  (tx_lrclk),
        .fall_tick (fall_tick),
        .load_tick (load_tick)
    );

    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [FW-1:0]     shift_q, shift_d;
    logic              dly_q, dly_d;
    logic              sd_q, sd_d;
    logic              underrun_q, underrun_d;
    logic [SLOT_W-1:0] slot_l, slot_r;
    logic [FW-1:0]     load_frame;
    logic [FW-1:0]     underrun_frame;
    logic              accept;

`ifdef I2S_TX_REPEAT_EN
    logic [FW-1:0] last_q, last_d;
    logic [7:0]    ur_cnt_q, ur_cnt_d;
`endif

    // The hold register may be refilled in the same cycle it drains into the shifter.
    assign tx_ready = ~hold_full_q | load_tick;
    assign accept   = tx_valid & tx_ready;

    always_comb begin
        slot_l = '0;
        slot_r = '0;
        slot_l[SLOT_W-1 -: DATA_W] = hold_l_q;
        slot_r[SLOT_W-1 -: DATA_W] = hold_r_q;
        load_frame = {slot_l, slot_r};
    end

`ifdef I2S_TX_REPEAT_EN
    assign underrun_frame = last_q;
`else
    assign underrun_frame = '0;
`endif

    always_comb begin
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        shift_d     = shift_q;
        dly_d       = dly_q;
        sd_d        = sd_q;
        underrun_d  = 1'b0;
`ifdef I2S_TX_REPEAT_EN
        last_d   = last_q;
        ur_cnt_d = ur_cnt_q;
`endif

        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = tx_data_l;
            hold_r_d    = tx_data_r;
        end else if (load_tick) begin
            hold_full_d = 1'b0;
        end

        if (load_tick) begin
            if (hold_full_q) begin
                shift_d = load_frame;
`ifdef I2S_TX_REPEAT_EN
                last_d = load_frame;
`endif
            end else begin
                shift_d    = underrun_frame;
                underrun_d = 1'b1;
`ifdef I2S_TX_REPEAT_EN
                if (ur_cnt_q != 8'hFF) ur_cnt_d = ur_cnt_q + 8'd1;
`endif
            end
        end else if (fall_tick) begin
            shift_d = shift_q << 1;
        end

        // Philips framing delays the data by one SCLK through dly_q.
        if (fall_tick) begin
            dly_d = shift_d[FW-1];
            sd_d  = (MODE == I2S_MODE_LJ) ? shift_d[FW-1] : dly_q;
        end
    end

    always_ff @(posedge clk_i2s or posedge reset) begin
        if (reset) begin
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            shift_q     <= '0;
            dly_q       <= 1'b0;
            sd_q        <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            shift_q     <= shift_d;
            dly_q       <= dly_d;
            sd_q        <= sd_d;
            underrun_q  <= underrun_d;
        end
    end

`ifdef I2S_TX_REPEAT_EN
    always_ff @(posedge clk_i2s or posedge reset) begin
        if (reset) begin
            last_q   <= '0;
            ur_cnt_q <= '0;
        end else begin
            last_q   <= last_d;
            ur_cnt_q <= ur_cnt_d;
        end
    end

    assign tx_underrun_cnt = ur_cnt_q;
`endif

    assign tx_mclk     = clk_i2s;
    assign tx_sd       = sd_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Directed bench for i2s_tx_stream: a Philips/24-bit instance, an LJ instance
// and a 16-in-16 Philips instance, each decoded by an SCLK-rise receiver.
module tb_i2s_tx_stream;
    import i2s_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_valid = 1'b0;
    logic [23:0] data_l = '0;
    logic [23:0] data_r = '0;
    logic valid2 = 1'b1;
    logic [15:0] d2l = 16'hA5C3;
    logic [15:0] d2r = 16'h3C5B;

    logic ready0, mclk0, sclk0, lr0, sd0, ur0;
    logic ready1, mclk1, sclk1, lr1, sd1, ur1;
    logic ready2, mclk2, sclk2, lr2, sd2, ur2;
`ifdef I2S_TX_REPEAT_EN
    logic [7:0] cnt0, cnt1, cnt2;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    i2s_tx_stream dut0 (
        .clk_i2s(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(ready0),
        .tx_data_l(data_l), .tx_data_r(data_r), .tx_mclk(mclk0), .tx_sclk(sclk0),
        .tx_lrclk(lr0), .tx_sd(sd0), .tx_underrun(ur0)
`ifdef I2S_TX_REPEAT_EN
        , .tx_underrun_cnt(cnt0)
`endif
    );

    i2s_tx_stream #(.MODE(I2S_MODE_LJ)) dut1 (
        .clk_i2s(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(ready1),
        .tx_data_l(data_l), .tx_data_r(data_r), .tx_mclk(mclk1), .tx_sclk(sclk1),
        .tx_lrclk(lr1), .tx_sd(sd1), .tx_underrun(ur1)
`ifdef I2S_TX_REPEAT_EN
        , .tx_underrun_cnt(cnt1)
`endif
    );

    i2s_tx_stream #(.DATA_W(16), .SLOT_W(16)) dut2 (
        .clk_i2s(clk), .reset(reset), .tx_valid(valid2), .tx_ready(ready2),
        .tx_data_l(d2l), .tx_data_r(d2r), .tx_mclk(mclk2), .tx_sclk(sclk2),
        .tx_lrclk(lr2), .tx_sd(sd2), .tx_underrun(ur2)
`ifdef I2S_TX_REPEAT_EN
        , .tx_underrun_cnt(cnt2)
`endif
    );

    // Receivers: sample tx_sd at each SCLK rise, frame starts at first rise with LRCLK low.
    logic [63:0] frames0[$];
    logic [63:0] frames1[$];
    logic [31:0] frames2[$];
    logic [63:0] cur0, cur1;
    logic [31:0] cur2;
    int pos0, pos1, pos2;
    logic lrp0, lrp1, lrp2, sp0, sp1, sp2;
    int ur_cyc0;

    always @(negedge clk) begin
        if (reset) begin
            frames0.delete(); frames1.delete(); frames2.delete();
            cur0 = '0; cur1 = '0; cur2 = '0;
            pos0 = 0; pos1 = 0; pos2 = 0;
            lrp0 = 1'b1; lrp1 = 1'b1; lrp2 = 1'b1;
            sp0 = 1'b1; sp1 = 1'b1; sp2 = 1'b1;
            ur_cyc0 = 0;
        end else begin
            if (ur0) ur_cyc0++;
            if (sclk0 && !sp0) begin
                if (!lr0 && lrp0) pos0 = 0; else pos0++;
                lrp0 = lr0;
                if (pos0 < 64) cur0[63-pos0] = sd0;
                if (pos0 == 63) frames0.push_back(cur0);
            end
            if (sclk1 && !sp1) begin
                if (!lr1 && lrp1) pos1 = 0; else pos1++;
                lrp1 = lr1;
                if (pos1 < 64) cur1[63-pos1] = sd1;
                if (pos1 == 63) frames1.push_back(cur1);
            end
            if (sclk2 && !sp2) begin
                if (!lr2 && lrp2) pos2 = 0; else pos2++;
                lrp2 = lr2;
                if (pos2 < 32) cur2[31-pos2] = sd2;
                if (pos2 == 31) frames2.push_back(cur2);
            end
            sp0 = sclk0; sp1 = sclk1; sp2 = sclk2;
        end
    end

    function automatic logic [63:0] ph_frame(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    function automatic logic [63:0] lj_frame(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'b0, r, 8'b0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_frames(input int n0, input int n2);
        int t;
        t = 0;
        while ((frames0.size() < n0 || frames2.size() < n2) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (frames0.size() < n0 || frames2.size() < n2) begin
            checks++;
            $display("FAIL wait_frames: have %0d/%0d frames, need %0d/%0d",
                     frames0.size(), frames2.size(), n0, n2);
        end
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r, output int stall);
        tx_valid = 1'b1;
        data_l = l;
        data_r = r;
        stall = 0;
        while (!ready0 && stall < 1000) begin
            @(negedge clk);
            stall++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tx_valid = 1'b1;
        data_l = 24'hDEADBE;
        data_r = 24'hBEEF01;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (sclk0 !== 1'b1) $display("FAIL reset_sclk: got %b want 1", sclk0); else passed++;
        checks++; if (lr0 !== 1'b1) $display("FAIL reset_lrclk: got %b want 1", lr0); else passed++;
        checks++; if (sd0 !== 1'b0) $display("FAIL reset_sd: got %b want 0", sd0); else passed++;
        checks++; if (ready0 !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready0); else passed++;
        checks++; if (ur0 !== 1'b0) $display("FAIL reset_underrun: got %b want 0", ur0); else passed++;
        checks++; if (mclk0 !== clk) $display("FAIL reset_mclk: got %b want %b", mclk0, clk); else passed++;
`ifdef I2S_TX_REPEAT_EN
        checks++; if (cnt0 !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", cnt0); else passed++;
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_clocks();
        int cyc, last_rise, last_lr, bad_sclk, bad_align, bad_lr, rises, lr_edges;
        logic prev_sclk, prev_lr;
        cyc = 0; last_rise = -1; last_lr = -1;
        bad_sclk = 0; bad_align = 0; bad_lr = 0; rises = 0; lr_edges = 0;
        prev_sclk = sclk0;
        prev_lr = lr0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            cyc++;
            if (sclk0 && !prev_sclk) begin
                if (last_rise >= 0 && cyc - last_rise != 4) bad_sclk++;
                last_rise = cyc;
                rises++;
            end
            if (lr0 != prev_lr) begin
                if (!(prev_sclk && !sclk0)) bad_align++;
                if (last_lr >= 0 && cyc - last_lr != 128) bad_lr++;
                last_lr = cyc;
                lr_edges++;
            end
            prev_sclk = sclk0;
            prev_lr = lr0;
        end
        checks++; if (bad_sclk != 0) $display("FAIL sclk_period: %0d periods not 4 clk, want 0", bad_sclk); else passed++;
        checks++; if (rises != 150) $display("FAIL sclk_rises: got %0d want 150", rises); else passed++;
        checks++; if (bad_lr != 0) $display("FAIL lrclk_half_period: %0d runs not 128 clk, want 0", bad_lr); else passed++;
        checks++; if (lr_edges != 5) $display("FAIL lrclk_edges: got %0d want 5", lr_edges); else passed++;
        checks++; if (bad_align != 0) $display("FAIL lrclk_align: %0d edges off SCLK fall, want 0", bad_align); else passed++;
    endtask

    task automatic test_frames();
        logic [31:0] e2a, e2b;
        wait_frames(3, 3);
        e2a = {1'b0, d2l, d2r[15:1]};
        e2b = {d2r[0], d2l, d2r[15:1]};
        checks++; if (frames0[0] !== 64'd0) $display("FAIL ph_first_frame: got %h want 0", frames0[0]); else passed++;
        checks++; if (frames0[1] !== ph_frame(data_l, data_r)) $display("FAIL ph_frame1: got %h want %h", frames0[1], ph_frame(data_l, data_r)); else passed++;
        checks++; if (frames0[2] !== ph_frame(data_l, data_r)) $display("FAIL ph_frame2: got %h want %h", frames0[2], ph_frame(data_l, data_r)); else passed++;
        checks++; if (frames1[1] !== lj_frame(data_l, data_r)) $display("FAIL lj_frame1: got %h want %h", frames1[1], lj_frame(data_l, data_r)); else passed++;
        checks++; if (frames1[2] !== lj_frame(data_l, data_r)) $display("FAIL lj_frame2: got %h want %h", frames1[2], lj_frame(data_l, data_r)); else passed++;
        checks++; if (frames2[1] !== e2a) $display("FAIL full16_frame1: got %h want %h", frames2[1], e2a); else passed++;
        checks++; if (frames2[2] !== e2b) $display("FAIL full16_frame2: got %h want %h", frames2[2], e2b); else passed++;
        checks++; if (ur_cyc0 != 1) $display("FAIL steady_underruns: got %0d want 1", ur_cyc0); else passed++;
    endtask

    task automatic test_back_to_back();
        int st_a, st_b, st_c;
        tx_valid = 1'b0;
        do_reset();
        @(negedge clk);
        checks++; if (ur0 !== 1'b1) $display("FAIL b2b_first_underrun: got %b want 1", ur0); else passed++;
        checks++; if (ready0 !== 1'b1) $display("FAIL b2b_ready_empty: got %b want 1", ready0); else passed++;
        send_pair(24'hDEADBE, 24'hBEEF01, st_a);
        send_pair(24'h123456, 24'hABCDEF, st_b);
        send_pair(24'h0F0F0F, 24'hF0F0F1, st_c);
        tx_valid = 1'b0;
        checks++; if (st_a != 0) $display("FAIL b2b_stall_a: got %0d want 0", st_a); else passed++;
        checks++; if (st_b != 254) $display("FAIL b2b_stall_b: got %0d want 254", st_b); else passed++;
        checks++; if (st_c != 255) $display("FAIL b2b_stall_c: got %0d want 255", st_c); else passed++;
        wait_frames(5, 0);
        checks++; if (frames0[1] !== ph_frame(24'hDEADBE, 24'hBEEF01)) $display("FAIL b2b_frame_a: got %h", frames0[1]); else passed++;
        checks++; if (frames0[2] !== ph_frame(24'h123456, 24'hABCDEF)) $display("FAIL b2b_frame_b: got %h", frames0[2]); else passed++;
        checks++; if (frames0[3] !== ph_frame(24'h0F0F0F, 24'hF0F0F1)) $display("FAIL b2b_frame_c: got %h", frames0[3]); else passed++;
        checks++; if (frames1[3] !== lj_frame(24'h0F0F0F, 24'hF0F0F1)) $display("FAIL b2b_lj_frame_c: got %h", frames1[3]); else passed++;
`ifdef I2S_TX_REPEAT_EN
        checks++; if (frames0[4] !== ph_frame(24'h0F0F0F, 24'hF0F0F1)) $display("FAIL underrun_repeat: got %h", frames0[4]); else passed++;
        checks++; if (cnt0 !== 8'd2) $display("FAIL underrun_cnt: got %0d want 2", cnt0); else passed++;
`else
        checks++; if (frames0[4] !== 64'd0) $display("FAIL underrun_zero: got %h want 0", frames0[4]); else passed++;
`endif
        checks++; if (ur_cyc0 != 2) $display("FAIL underrun_pulse_cycles: got %0d want 2", ur_cyc0); else passed++;
    endtask

    task automatic test_reset_mid();
        int t;
        tx_valid = 1'b1;
        data_l = 24'hDEADBE;
        data_r = 24'hBEEF01;
        t = 0;
        while (!(frames0.size() >= 7 && pos0 == 10 && lr0 == 1'b0) && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 4000) begin
            checks++;
            $display("FAIL mid_reset_wait: left bit 10 not reached, frames %0d", frames0.size());
        end
        reset = 1'b1;
        #1;
        checks++; if (sclk0 !== 1'b1) $display("FAIL mid_reset_sclk: got %b want 1", sclk0); else passed++;
        checks++; if (lr0 !== 1'b1) $display("FAIL mid_reset_lrclk: got %b want 1", lr0); else passed++;
        checks++; if (sd0 !== 1'b0) $display("FAIL mid_reset_sd: got %b want 0", sd0); else passed++;
        checks++; if (ready0 !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", ready0); else passed++;
        checks++; if (lr2 !== 1'b1) $display("FAIL mid_reset_lrclk16: got %b want 1", lr2); else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (sclk0 !== 1'b0) $display("FAIL post_reset_sclk: got %b want 0", sclk0); else passed++;
        checks++; if (lr0 !== 1'b0) $display("FAIL post_reset_lrclk: got %b want 0", lr0); else passed++;
        checks++; if (ur0 !== 1'b1) $display("FAIL post_reset_underrun: got %b want 1", ur0); else passed++;
        checks++; if (ready0 !== 1'b0) $display("FAIL post_reset_ready: got %b want 0", ready0); else passed++;
        wait_frames(2, 0);
        checks++; if (frames0[0] !== 64'd0) $display("FAIL post_reset_frame0: got %h want 0", frames0[0]); else passed++;
        checks++; if (frames0[1] !== ph_frame(24'hDEADBE, 24'hBEEF01)) $display("FAIL post_reset_frame1: got %h", frames0[1]); else passed++;
    endtask

`ifdef I2S_TX_REPEAT_EN
    task automatic test_saturate();
        tx_valid = 1'b0;
        repeat (260 * 256) @(negedge clk);
        checks++; if (cnt0 !== 8'd255) $display("FAIL underrun_cnt_sat: got %0d want 255", cnt0); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_clocks();
        test_frames();
        test_back_to_back();
        test_reset_mid();
`ifdef I2S_TX_REPEAT_EN
        test_saturate();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
